// File: rtl/mem_access_unit.sv
// Multi-cycle controller to req/ack memory bridge holding IR and MDR.
// Optional ALIGN_CHECK_EN: misaligned addresses fault instead of being truncated.
module mem_access_unit #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              ir_write,
  input  logic              iord,
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] alu_out,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] ir,
  output logic [DATA_W-1:0] mdr,
  output logic              stall,
  output logic              bus_err,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_ack
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DONE
  } state_t;

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

  state_t state;
  state_t state_n;

  logic [CW-1:0]     cnt;
  logic              op;
  logic              tgt_ir;
  logic              misal;
  logic              ack_hit;
  logic              to_hit;
  logic [ADDR_W-1:0] addr_sel;
  logic [ADDR_W-1:0] addr_cap;
  logic [DATA_W-1:0] rd_val;

  assign op       = mem_read | mem_write;
  assign addr_sel = iord ? alu_out : pc;

`ifdef ALIGN_CHECK_EN
  assign misal    = |addr_sel[1:0];
  assign addr_cap = addr_sel;
`else
  assign misal    = 1'b0;
  assign addr_cap = addr_sel & {{(ADDR_W-2){1'b1}}, 2'b00};
`endif

  assign ack_hit = (state == REQ) & m_ack;
  assign to_hit  = (state == REQ) & ~m_ack & (cnt == CNT_MAX);
  // A timed-out read returns zero rather than whatever is on the bus.
  assign rd_val  = ack_hit ? m_rdata : '0;

  // Gated by reset so the controller is released the instant reset hits.
  assign stall = rst & op & (state != DONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (op) begin
          state_n = misal ? DONE : REQ;
        end
      end
      REQ: begin
        if (ack_hit || to_hit) begin
          state_n = DONE;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ir      <= '0;
      mdr     <= '0;
      bus_err <= 1'b0;
      m_req   <= 1'b0;
      m_we    <= 1'b0;
      m_addr  <= '0;
      m_wdata <= '0;
      tgt_ir  <= 1'b0;
      cnt     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (op) begin
            m_addr  <= addr_cap;
            m_we    <= mem_write;
            m_wdata <= wdata;
            tgt_ir  <= ir_write;
            if (misal) begin
              bus_err <= 1'b1;
              if (!mem_write) begin
                if (ir_write) begin
                  ir <= '0;
                end else begin
                  mdr <= '0;
                end
              end
            end else begin
              m_req <= 1'b1;
            end
          end
        end
        REQ: begin
          unique case (1'b1)
            ack_hit, to_hit: begin
              m_req <= 1'b0;
              if (to_hit) begin
                bus_err <= 1'b1;
              end
              if (!m_we) begin
                if (tgt_ir) begin
                  ir <= rd_val;
                end else begin
                  mdr <= rd_val;
                end
              end
            end
            default: begin
              cnt <= cnt + 1'b1;
            end
          endcase
        end
        DONE: begin
          cnt <= '0;
        end
        default: begin
          cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: driver pushes expectations,
// negedge monitor pops and checks at each completion (DONE cycle).
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read, mem_write, ir_write, iord;
  logic [31:0] pc, alu_out, wdata;
  logic [31:0] ir, mdr;
  logic        stall, bus_err;
  logic        m_req, m_we;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic        m_ack;

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .iord(iord),
    .pc(pc), .alu_out(alu_out), .wdata(wdata),
    .ir(ir), .mdr(mdr), .stall(stall), .bus_err(bus_err),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_rdata(m_rdata), .m_ack(m_ack)
  );

  typedef struct {
    logic [31:0] ir;
    logic [31:0] mdr;
    logic        err;
    int          stalls;
    int          reqs;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wd;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] i, input logic [31:0] m,
                              input logic e, input int s, input int r,
                              input logic [31:0] a, input logic w,
                              input logic [31:0] d);
    exp_t x;
    x.ir = i; x.mdr = m; x.err = e; x.stalls = s;
    x.reqs = r; x.addr = a; x.we = w; x.wd = d;
    return x;
  endfunction

  // Memory model: ack in REQ cycle number ack_at (0 = first).
  int          ack_at = 0;
  int          k = 0;
  logic [31:0] rd_val = '0;
  logic        spur_ack = 1'b0;

  always @(negedge clk) begin
    if (m_req) begin
      m_ack   = (k == ack_at);
      m_rdata = m_ack ? rd_val : 32'hFFFF_FFFF;
      k++;
    end else begin
      m_ack   = spur_ack;
      m_rdata = 32'hA5A5_A5A5;
      k = 0;
    end
  end

  // Monitor
  int          st_cnt = 0;
  int          rq_cnt = 0;
  logic        seen = 1'b0;
  logic [31:0] a_cap, wd_cap;
  logic        we_cap;
  exp_t        e_mon;

  always @(negedge clk) begin
    if (!rst) begin
      st_cnt = 0; rq_cnt = 0; seen = 1'b0;
    end else begin
      if (m_req) begin
        rq_cnt++;
        if (!seen) begin
          seen = 1'b1;
          a_cap = m_addr; we_cap = m_we; wd_cap = m_wdata;
        end
      end
      if (mem_read | mem_write) begin
        if (stall) begin
          st_cnt++;
        end else if (sb.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          e_mon = sb.pop_front();
          chk("ir", ir, e_mon.ir);
          chk("mdr", mdr, e_mon.mdr);
          chk("bus_err", {31'd0, bus_err}, {31'd0, e_mon.err});
          chk("stall_cycles", st_cnt, e_mon.stalls);
          chk("req_cycles", rq_cnt, e_mon.reqs);
          if (e_mon.reqs > 0) begin
            chk("m_addr", a_cap, e_mon.addr);
            chk("m_we", {31'd0, we_cap}, {31'd0, e_mon.we});
            chk("m_wdata", wd_cap, e_mon.wd);
          end
          st_cnt = 0; rq_cnt = 0; seen = 1'b0;
        end
      end
    end
  end

  task automatic set_in(input logic rd, input logic wr, input logic irw,
                        input logic io, input logic [31:0] p,
                        input logic [31:0] a, input logic [31:0] d);
    mem_read = rd; mem_write = wr; ir_write = irw; iord = io;
    pc = p; alu_out = a; wdata = d;
  endtask

  task automatic do_op(input logic rd, input logic wr, input logic irw,
                       input logic io, input logic [31:0] p,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] rv, input int ack, input exp_t e);
    bit done;
    sb.push_back(e);
    rd_val = rv;
    ack_at = ack;
    @(posedge clk); #1;
    set_in(rd, wr, irw, io, p, a, d);
    done = 0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      if (!stall) done = 1;
    end
    if (!done) chk("op_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    bit got;
    rst = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0);
    m_ack = 1'b0;
    m_rdata = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rst_ir", ir, 32'h0);
    chk("rst_mdr", mdr, 32'h0);
    chk("rst_err", {31'd0, bus_err}, 32'd0);
    chk("rst_mreq", {31'd0, m_req}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);

    // Fetch, load with waits, store priority, back-to-back fetch
    do_op(1, 0, 1, 0, 32'h40, 32'h0, 32'h0, 32'h8C220004, 0,
          mk(32'h8C220004, 32'h0, 0, 2, 1, 32'h40, 0, 32'h0));
    do_op(1, 0, 0, 1, 32'h40, 32'h104, 32'h0, 32'h12345678, 2,
          mk(32'h8C220004, 32'h12345678, 0, 4, 3, 32'h104, 0, 32'h0));
    do_op(1, 1, 0, 1, 32'h40, 32'h200, 32'hCAFEF00D, 32'h0, 1,
          mk(32'h8C220004, 32'h12345678, 0, 3, 2, 32'h200, 1, 32'hCAFEF00D));
    do_op(1, 0, 1, 0, 32'h44, 32'h0, 32'h0, 32'h00A51020, 0,
          mk(32'h00A51020, 32'h12345678, 0, 2, 1, 32'h44, 0, 32'h0));
    // Timeout: 16 REQ cycles, read register zeroed, sticky error
    do_op(1, 0, 0, 1, 32'h44, 32'h300, 32'h0, 32'h0, 99,
          mk(32'h00A51020, 32'h0, 1, 17, 16, 32'h300, 0, 32'h0));
    do_op(1, 0, 0, 1, 32'h44, 32'h108, 32'h0, 32'hDEADBEEF, 0,
          mk(32'h00A51020, 32'hDEADBEEF, 1, 2, 1, 32'h108, 0, 32'h0));

    // Async reset mid-REQ
    ack_at = 99;
    @(posedge clk); #1;
    set_in(1, 0, 1, 0, 32'h60, 32'h0, 32'h0);
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (m_req) got = 1;
    end
    if (!got) chk("reset_test_no_req", 32'd0, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("arst_mreq", {31'd0, m_req}, 32'd0);
    chk("arst_stall", {31'd0, stall}, 32'd0);
    chk("arst_ir", ir, 32'h0);
    chk("arst_mdr", mdr, 32'h0);
    chk("arst_err", {31'd0, bus_err}, 32'd0);
    set_in(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    @(posedge clk); #1 rst = 1'b1;

    do_op(1, 0, 1, 0, 32'h80, 32'h0, 32'h0, 32'h11112222, 1,
          mk(32'h11112222, 32'h0, 0, 3, 2, 32'h80, 0, 32'h0));
    do_op(1, 0, 0, 1, 32'h80, 32'h10C, 32'h0, 32'h0BADCAFE, 0,
          mk(32'h11112222, 32'h0BADCAFE, 0, 2, 1, 32'h10C, 0, 32'h0));
`ifdef ALIGN_CHECK_EN
    do_op(1, 0, 0, 1, 32'h80, 32'h102, 32'h0, 32'h55AA55AA, 0,
          mk(32'h11112222, 32'h0, 1, 1, 0, 32'h0, 0, 32'h0));
`else
    do_op(1, 0, 0, 1, 32'h80, 32'h102, 32'h0, 32'h55AA55AA, 0,
          mk(32'h11112222, 32'h55AA55AA, 0, 2, 1, 32'h100, 0, 32'h0));
`endif

    // Spurious acks while idle must be ignored
    @(posedge clk); #1;
    set_in(0, 0, 0, 0, 0, 0, 0);
    spur_ack = 1'b1;
    repeat (3) @(posedge clk);
    #1 spur_ack = 1'b0;
    @(negedge clk);
    chk("spur_ir", ir, 32'h11112222);
`ifdef ALIGN_CHECK_EN
    chk("spur_mdr", mdr, 32'h0);
`else
    chk("spur_mdr", mdr, 32'h55AA55AA);
`endif
    chk("spur_mreq", {31'd0, m_req}, 32'd0);

    for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
    chk("sb_empty", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
